// File: rtl/switch_sr_pulser.sv
// switch_sr_pulser: debounces an asynchronous mechanical switch and converts each
// accepted press into a one-cycle set pulse (s) and each accepted release into a
// one-cycle reset pulse (r). It also exposes the debounced level, a busy flag
// while a transition is being qualified, and a wrapping 8-bit press counter.
module switch_sr_pulser #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_raw,
  input  logic       en,
  output logic       s,
  output logic       r,
  output logic       level,
  output logic       busy,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    LOW  = 2'd0,
    RISE = 2'd1,
    HIGH = 2'd2,
    FALL = 2'd3
  } state_t;

  // The qualification counter already holds 1 on entry to RISE/FALL, so the
  // transition completes on the edge where it has reached N-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic       sync1_reg;
  logic       sync2_reg;

  state_t     state_reg,  state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic       s_reg,      s_next;
  logic       r_reg,      r_next;
  logic       level_reg,  level_next;
  logic [7:0] press_count_reg, press_count_next;

  // Two-flop synchronizer; runs regardless of en so the sample is always fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= sw_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= LOW;
      cnt_reg         <= '0;
      s_reg           <= 1'b0;
      r_reg           <= 1'b0;
      level_reg       <= 1'b0;
      press_count_reg <= 8'd0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      s_reg           <= s_next;
      r_reg           <= r_next;
      level_reg       <= level_next;
      press_count_reg <= press_count_next;
    end
  end

  // Next-state logic: qualify a new level for N consecutive enabled samples;
  // any opposite sample or a dropped enable falls back to the stable state.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    s_next           = 1'b0;
    r_next           = 1'b0;
    level_next       = level_reg;
    press_count_next = press_count_reg;

    unique case (state_reg)
      LOW: begin
        if (en && sync2_reg) begin
          state_next = RISE;
          cnt_next   = CNT_ONE;
        end
      end

      RISE: begin
        if (!sync2_reg || !en) begin
          state_next = LOW;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next       = HIGH;
          cnt_next         = '0;
          s_next           = 1'b1;
          level_next       = 1'b1;
          press_count_next = press_count_reg + 8'd1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      HIGH: begin
        if (en && !sync2_reg) begin
          state_next = FALL;
          cnt_next   = CNT_ONE;
        end
      end

      FALL: begin
        if (sync2_reg || !en) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = LOW;
          cnt_next   = '0;
          r_next     = 1'b1;
          level_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = LOW;
        cnt_next   = '0;
      end
    endcase
  end

  assign s           = s_reg;
  assign r           = r_reg;
  assign level       = level_reg;
  assign press_count = press_count_reg;
  assign busy        = (state_reg == RISE) || (state_reg == FALL);

endmodule

// File: tb/tb_switch_sr_pulser.sv
// Testbench for switch_sr_pulser: directed scenarios plus randomized switch
// activity, compared every cycle against a run-length reference model.
module tb_switch_sr_pulser;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_raw = 1'b0;
  logic       en = 1'b1;
  logic       s, r, level, busy;
  logic [7:0] press_count;

  int checks = 0;
  int failures = 0;

  // Reference model: the debouncer sees the raw level two edges late; a new
  // level is accepted after N consecutive enabled samples that differ from the
  // current one.
  logic       m_d1 = 1'b0, m_d2 = 1'b0;
  logic       m_lvl = 1'b0;
  int         m_run = 0;
  logic       m_s = 1'b0, m_r = 1'b0;
  logic [7:0] m_cnt = 8'd0;

  int s_seen = 0;
  int r_seen = 0;

  switch_sr_pulser #(.DEBOUNCE_CYCLES(N), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_raw      (sw_raw),
    .en          (en),
    .s           (s),
    .r           (r),
    .level       (level),
    .busy        (busy),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock, update the model with the inputs present at that edge,
  // then compare all outputs shortly after the edge.
  task automatic step();
    logic seen;
    @(posedge clk);
    if (rst) begin
      m_d1 = 1'b0; m_d2 = 1'b0; m_lvl = 1'b0; m_run = 0;
      m_s = 1'b0; m_r = 1'b0; m_cnt = 8'd0;
    end else begin
      seen = m_d2;
      m_d2 = m_d1;
      m_d1 = sw_raw;
      m_s = 1'b0;
      m_r = 1'b0;
      if (en && (seen != m_lvl)) begin
        m_run++;
        if (m_run == N) begin
          m_lvl = ~m_lvl;
          m_run = 0;
          if (m_lvl) begin
            m_s = 1'b1;
            m_cnt = m_cnt + 8'd1;
          end else begin
            m_r = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
    end
    #1;
    check_eq("s", s, m_s);
    check_eq("r", r, m_r);
    check_eq("level", level, m_lvl);
    check_eq("busy", busy, (m_run > 0));
    check_eq("press_count", press_count, m_cnt);
    check_eq("s_r_exclusive", s & r, 1'b0);
    if (s) s_seen++;
    if (r) r_seen++;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset held three cycles with the switch already high.
    rst = 1'b1; sw_raw = 1'b1; en = 1'b1;
    hold(3);
    rst = 1'b0;
    hold(1);
    sw_raw = 1'b0;
    hold(20);
    $display("phase reset: press_count=%0d level=%0d", press_count, level);

    // Clean press then release.
    s_seen = 0; r_seen = 0;
    sw_raw = 1'b1; hold(20);
    sw_raw = 1'b0; hold(20);
    check_eq("clean_s_total", s_seen, 1);
    check_eq("clean_r_total", r_seen, 1);
    $display("phase clean: s=%0d r=%0d press_count=%0d", s_seen, r_seen, press_count);

    // Bounce: 3 high, 1 low, 2 high, low.
    s_seen = 0;
    sw_raw = 1'b1; hold(3);
    sw_raw = 1'b0; hold(1);
    sw_raw = 1'b1; hold(2);
    sw_raw = 1'b0; hold(10);
    check_eq("bounce_s_total", s_seen, 0);
    $display("phase bounce: s=%0d level=%0d", s_seen, level);

    // Enable gating, then release.
    s_seen = 0;
    en = 1'b0; sw_raw = 1'b1; hold(20);
    check_eq("gated_s_total", s_seen, 0);
    en = 1'b1; hold(8);
    check_eq("ungated_s_total", s_seen, 1);
    sw_raw = 1'b0; hold(10);
    $display("phase enable: s=%0d press_count=%0d", s_seen, press_count);

    // Reset in the middle of a rising qualification.
    rst = 1'b1; hold(1); rst = 1'b0; hold(4);
    s_seen = 0;
    sw_raw = 1'b1; hold(4);
    rst = 1'b1; hold(1); rst = 1'b0;
    sw_raw = 1'b0; hold(10);
    check_eq("midrise_s_total", s_seen, 0);
    check_eq("midrise_press_count", press_count, 8'd0);
    $display("phase mid-rise reset: press_count=%0d", press_count);

    // Randomized activity: random hold lengths, occasional en drops and resets.
    for (int t = 0; t < 400; t++) begin
      sw_raw = $urandom_range(1, 0);
      en = ($urandom_range(9, 0) != 0);
      rst = ($urandom_range(79, 0) == 0);
      hold($urandom_range(N + 3, 1));
    end
    rst = 1'b0; en = 1'b1; sw_raw = 1'b0;
    hold(10);
    $display("phase random: press_count=%0d level=%0d", press_count, level);

    // Wrap: 256 clean press/release pairs from a fresh reset.
    rst = 1'b1; hold(1); rst = 1'b0; hold(4);
    s_seen = 0; r_seen = 0;
    for (int i = 0; i < 256; i++) begin
      sw_raw = 1'b1; hold(N + 3);
      if (i == 254) check_eq("wrap_count_255", press_count, 8'd255);
      if (i == 255) check_eq("wrap_count_0", press_count, 8'd0);
      sw_raw = 1'b0; hold(N + 3);
    end
    hold(4);
    check_eq("wrap_s_total", s_seen, 256);
    check_eq("wrap_r_total", r_seen, 256);
    $display("phase wrap: s=%0d r=%0d press_count=%0d", s_seen, r_seen, press_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_sr_pulser.md
# switch_sr_pulser

Debounce and edge-encoding front end for the SR switch. Takes a raw, asynchronous, bouncing mechanical switch level and produces the clean set and reset command pulses the SR switch consumes. Each stable press emits a one-cycle `s` pulse and each stable release emits a one-cycle `r` pulse. The block sits between the board pin and the SR switch instance, on the same `clk`.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized samples required to accept a new level. Legal minimum is 2.
- `CNT_W`, default 16: debounce counter width. `DEBOUNCE_CYCLES` must be less than 2^`CNT_W`.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `sw_raw`  input  1  raw switch level; asynchronous to `clk`.
- `en`  input  1  qualification enable; pulses are suppressed while low.
- `s`  output  1  one-cycle set pulse on an accepted 0->1 transition.
- `r`  output  1  one-cycle reset pulse on an accepted 1->0 transition.
- `level`  output  1  debounced switch level.
- `busy`  output  1  high while a candidate transition is being qualified.
- `press_count`  output  8  count of emitted `s` pulses; wraps modulo 256.

## Operation
- **Synchronizer:** a 2-flop chain `sw_raw` -> `sync1` -> `sync2`.
  - `sync2` is the only sample the FSM uses.
  - The chain runs regardless of `en`.
- **FSM states:**
  - `LOW`: stable 0.
  - `RISE`: qualifying 1.
  - `HIGH`: stable 1.
  - `FALL`: qualifying 0.
- **`LOW`:**
  - If `en` and `sync2`=1, go to `RISE` with `cnt`=1.
  - Otherwise stay in `LOW`.
- **`RISE`:**
  - If `sync2`=0 or `en`=0, return to `LOW` with `cnt`=0. No pulse.
  - Else if `cnt`=`DEBOUNCE_CYCLES`-1, go to `HIGH`. Register `s`=1, `level`=1, and `press_count`+1.
  - Else `cnt`+1.
- **`HIGH` and `FALL`:** mirror `LOW` and `RISE`.
  - `FALL` completing registers `r`=1 and `level`=0.
  - `press_count` is unchanged on a release.
- **Pulse width:** `s` and `r` are registered and high for exactly one cycle. They are never high in the same cycle.
- **Counter reset:** `cnt` resets to 0 on every entry to `LOW` or `HIGH`.
- **`busy`:** equals (state is `RISE` or `FALL`), decoded from registered state.
- **Disable:** `en`=0 in `LOW` or `HIGH` holds the state; `level` is kept.
- **`press_count` arithmetic:** unsigned 8-bit; 255+1 = 0, with no flag.

## Timing
- **Reset values:**
  - `s`=0, `r`=0, `level`=0, `busy`=0, `press_count`=0.
  - State = `LOW`, `cnt`=0, `sync1`=`sync2`=0.
- **Reset mid-qualification:** reset during `RISE` or `FALL` aborts with no pulse. State returns to `LOW` even if `level` was 1. No `r` pulse is emitted for that forced drop.
- **Latency:** if `sw_raw` is first sampled at edge k and held, the FSM sees `sync2`=1 at edge k+2.
  - For N = `DEBOUNCE_CYCLES`, `s` and `level` are registered at edge k+N+1.
  - `s` is high for the cycle following edge k+N+1.
  - The same latency applies to `r` on release.
- **Bounce:** any opposite sample before N consecutive samples restarts qualification from the stable state. A glitch shorter than N synchronized cycles produces no pulse.
- **Re-arming:**
  - After `s`, a release can begin qualification on the very next edge.
  - The minimum spacing between an `s` and the following `r` is N cycles.
- **Simultaneous events:**
  - `rst` overrides everything.
  - `en` falling on the completing edge of `RISE`/`FALL` cancels the transition; no pulse.

## Test plan
- **Reset:** assert `rst` for 3 cycles with `sw_raw`=1 -> all outputs 0 during reset and the cycle after. Then a clean rising qualification starts.
- **Clean press/release (N=4):**
  - `sw_raw` 0->1 sampled at edge 10 and held 20 cycles -> `busy` high from edge 12. `s`=1 for only the cycle after edge 15. `level`=1 and `press_count`=1 from edge 15.
  - Release sampled at edge 40 -> `r` pulse after edge 45, `level`=0, `press_count` stays 1.
- **Bounce:** `sw_raw` high 3 cycles, low 1, high 2, low -> no `s`, `level` stays 0, `busy` returns to 0.
- **Enable gating:** `en`=0 while `sw_raw` is held high 20 cycles -> no `s`, `level`=0. Raise `en` -> `s` pulse 4 cycles later (`LOW` -> `RISE` on the first enabled edge, then 3 more cycles).
- **Reset mid-`RISE`:** `rst` pulsed at `cnt`=2 -> state returns to `LOW`, no `s`, `press_count` unchanged at 0.
- **Wrap:** 256 clean press/release pairs -> 256 `s` pulses and 256 `r` pulses. `press_count` reads 255 after the 255th press and 0 after the 256th.
